// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a direct-mapped, write-through,
// no-write-allocate cache with saturating hit/miss statistics.

module cache_ctrl #(
    parameter int WIDTH = 64,
    parameter int ASIZE = 4,
    parameter int TSIZE = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [TSIZE+ASIZE-1:0]   cpu_addr,
    input  logic [WIDTH-1:0]         cpu_wdata,
    output logic                     cpu_ready,
    output logic                     cpu_rvalid,
    output logic [WIDTH-1:0]         cpu_rdata,
    output logic                     cpu_wack,
    output logic                     arr_re,
    output logic [ASIZE-1:0]         arr_raddr,
    input  logic [WIDTH-1:0]         arr_dout,
    output logic                     arr_we,
    output logic [ASIZE-1:0]         arr_waddr,
    output logic [WIDTH-1:0]         arr_din,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [TSIZE+ASIZE-1:0]   mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic                     mem_ack,
    input  logic [WIDTH-1:0]         mem_rdata,
    output logic [15:0]              hit_cnt,
    output logic [15:0]              miss_cnt
);

    localparam int LINES = 1 << ASIZE;
    localparam int AW    = TSIZE + ASIZE;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RD_RESP,
        MEM_RD,
        FILL,
        MEM_WR,
        WR_DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [AW-1:0]                 addr_q, addr_d;
    logic [WIDTH-1:0]              wdata_q, wdata_d;
    logic [WIDTH-1:0]              mdata_q, mdata_d;
    logic [WIDTH-1:0]              hold_q, hold_d;
    logic                          hit_q, hit_d;
    logic [15:0]                   hit_cnt_q, hit_cnt_d;
    logic [15:0]                   miss_cnt_q, miss_cnt_d;
    logic [LINES-1:0]              valid_q, valid_d;
    logic [LINES-1:0][TSIZE-1:0]   tag_q, tag_d;

    logic [ASIZE-1:0]              req_idx;
    logic [TSIZE-1:0]              req_tag;
    logic [ASIZE-1:0]              lat_idx;
    logic [TSIZE-1:0]              lat_tag;
    logic                          lookup_hit;

    assign req_idx    = cpu_addr[ASIZE-1:0];
    assign req_tag    = cpu_addr[AW-1:ASIZE];
    assign lat_idx    = addr_q[ASIZE-1:0];
    assign lat_tag    = addr_q[AW-1:ASIZE];
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath updates and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mdata_d    = mdata_q;
        hold_d     = hold_q;
        hit_d      = hit_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = valid_q;
        tag_d      = tag_q;

        cpu_ready  = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = hold_q;
        cpu_wack   = 1'b0;
        arr_re     = 1'b0;
        arr_raddr  = '0;
        arr_we     = 1'b0;
        arr_waddr  = '0;
        arr_din    = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                cpu_ready = !flush;
                if (flush) begin
                    valid_d = '0;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    hit_d   = lookup_hit;
                    if (lookup_hit) begin
                        if (hit_cnt_q != 16'hFFFF) begin
                            hit_cnt_d = hit_cnt_q + 16'd1;
                        end
                    end else begin
                        if (miss_cnt_q != 16'hFFFF) begin
                            miss_cnt_d = miss_cnt_q + 16'd1;
                        end
                    end
                    if (cpu_we) begin
                        state_d = MEM_WR;
                    end else if (lookup_hit) begin
                        state_d = LOOKUP;
                    end else begin
                        state_d = MEM_RD;
                    end
                end
            end
            LOOKUP: begin
                arr_re    = 1'b1;
                arr_raddr = lat_idx;
                state_d   = RD_RESP;
            end
            RD_RESP: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = arr_dout;
                hold_d     = arr_dout;
                state_d    = IDLE;
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) begin
                    mdata_d = mem_rdata;
                    state_d = FILL;
                end
            end
            FILL: begin
                arr_we           = 1'b1;
                arr_waddr        = lat_idx;
                arr_din          = mdata_q;
                tag_d[lat_idx]   = lat_tag;
                valid_d[lat_idx] = 1'b1;
                cpu_rvalid       = 1'b1;
                cpu_rdata        = mdata_q;
                hold_d           = mdata_q;
                state_d          = IDLE;
            end
            MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                cpu_wack = 1'b1;
                // no-write-allocate: only a line that already holds
                // this address is refreshed
                if (hit_q) begin
                    arr_we    = 1'b1;
                    arr_waddr = lat_idx;
                    arr_din   = wdata_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line state, latched request and statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            mdata_q    <= '0;
            hold_q     <= '0;
            hit_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
            tag_q      <= '0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mdata_q    <= mdata_d;
            hold_q     <= hold_d;
            hit_q      <= hit_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
        end
    end

endmodule
